ga_cmd_streamer: RTL and testbench

//  Upstream feeder for the Accelerator: buffers scene-command bytes (zoom, angle, object count, object records)
//  and issues them one byte per transaction on the AXI-lite style write port (AW/W/B) into the Accelerator slave.

---
 rtl/ga_axi_pkg.sv | 16 +
 rtl/ga_cmd_fifo.sv | 70 +++++++
 rtl/ga_cmd_streamer.sv | 176 +++++++++++++++++
 tb/tb_ga_cmd_streamer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ga_axi_pkg.sv
// Shared encodings for the command streamer: AXI response codes,
// write protection attribute and the sequencer state type.
package ga_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] AWPROT_DATA = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2,
        HALT = 2'd3
    } state_t;

endpackage

// File: rtl/ga_cmd_fifo.sv
// Synchronous command FIFO with flush. The full flag is registered so
// the upstream ready does not depend on a same-cycle pop.
module ga_cmd_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    input  logic             flush,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push & ~full & ~flush;
    assign do_pop   = pop & ~empty & ~flush;
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Occupancy after this cycle's push/pop; flush empties everything.
    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (do_push && !do_pop) begin
            count_nxt = count + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count - (AW+1)'(1);
        end
    end

    // Pointers, occupancy and the registered full flag.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
        end
    end

    // Storage array; no reset needed since empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ga_cmd_streamer.sv
// Command byte streamer: buffers host bytes and issues one AXI-lite
// write per byte, tracking responses and halting on render-end.
module ga_cmd_streamer
    import ga_axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CMD_ADDR   = 1
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    restart,
    output logic [ADDR_WIDTH-1:0]   oAWADDR,
    output logic [2:0]              oAWPROT,
    output logic                    oAWVALID,
    input  logic                    iAWREADY,
    output logic [DATA_WIDTH-1:0]   oWDATA,
    output logic [DATA_WIDTH/8-1:0] oWSTRB,
    output logic                    oWVALID,
    input  logic                    iWREADY,
    output logic                    oBREADY,
    input  logic                    iBVALID,
    input  logic [1:0]              iBRESP,
    input  logic                    RenderEndInterrupt,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             sent_count,
    output logic [7:0]              err_count
);

    state_t                  state, state_nxt;
    logic                    aw_done, aw_done_nxt;
    logic                    w_done, w_done_nxt;
    logic                    int_seen, int_seen_nxt;
    logic                    awvalid_nxt, wvalid_nxt, bready_nxt, done_nxt;
    logic [DATA_WIDTH-1:0]   wdata_nxt;
    logic [ADDR_WIDTH-1:0]   awaddr_nxt;
    logic [2:0]              awprot_nxt;
    logic [DATA_WIDTH/8-1:0] wstrb_nxt;
    logic [15:0]             sent_base, sent_nxt;
    logic [7:0]              err_base, err_nxt;
    logic                    aw_fin, w_fin;
    logic                    fifo_pop, fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0]   fifo_rd_data;

    assign in_ready = ~fifo_full & (state != HALT);
    assign busy     = (state != IDLE) | ~fifo_empty;

    ga_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (ACLK),
        .nreset    (ARESETn),
        .push      (in_valid & in_ready),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .flush     (restart),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        state_nxt    = state;
        aw_done_nxt  = aw_done;
        w_done_nxt   = w_done;
        awvalid_nxt  = oAWVALID;
        wvalid_nxt   = oWVALID;
        bready_nxt   = oBREADY;
        wdata_nxt    = oWDATA;
        awaddr_nxt   = oAWADDR;
        awprot_nxt   = oAWPROT;
        wstrb_nxt    = oWSTRB;
        done_nxt     = 1'b0;
        fifo_pop     = 1'b0;
        aw_fin       = aw_done | (oAWVALID & iAWREADY);
        w_fin        = w_done | (oWVALID & iWREADY);
        // restart beats a simultaneous interrupt; a held level is recaptured next cycle
        int_seen_nxt = ~restart & (int_seen | RenderEndInterrupt);
        // counters clear first so a completion in the restart cycle is still counted
        sent_base    = restart ? '0 : sent_count;
        err_base     = restart ? '0 : err_count;
        sent_nxt     = sent_base;
        err_nxt      = err_base;
        case (state)
            IDLE: begin
                // a restart cycle launches nothing: the FIFO head is being flushed
                if (!restart) begin
                    if (int_seen) begin
                        state_nxt = HALT;
                        done_nxt  = 1'b1;
                    end else if (!fifo_empty) begin
                        fifo_pop    = 1'b1;
                        wdata_nxt   = fifo_rd_data;
                        awaddr_nxt  = ADDR_WIDTH'(CMD_ADDR);
                        awprot_nxt  = AWPROT_DATA;
                        wstrb_nxt   = '1;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        aw_done_nxt = 1'b0;
                        w_done_nxt  = 1'b0;
                        state_nxt   = SEND;
                    end
                end
            end
            SEND: begin
                awvalid_nxt = oAWVALID & ~iAWREADY;
                wvalid_nxt  = oWVALID & ~iWREADY;
                aw_done_nxt = aw_fin;
                w_done_nxt  = w_fin;
                if (aw_fin && w_fin) begin
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    bready_nxt  = 1'b1;
                    state_nxt   = RESP;
                end
            end
            RESP: begin
                if (iBVALID && oBREADY) begin
                    bready_nxt = 1'b0;
                    sent_nxt   = sent_base + 16'd1;
                    if (iBRESP != RESP_OKAY && err_base != 8'hFF) begin
                        err_nxt = err_base + 8'd1;
                    end
                    state_nxt = IDLE;
                end
            end
            HALT: begin
                if (restart) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, handshake flags, AXI outputs and counters.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state      <= IDLE;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            int_seen   <= 1'b0;
            oAWVALID   <= 1'b0;
            oWVALID    <= 1'b0;
            oBREADY    <= 1'b0;
            oWDATA     <= '0;
            oAWADDR    <= '0;
            oAWPROT    <= '0;
            oWSTRB     <= '0;
            done       <= 1'b0;
            sent_count <= '0;
            err_count  <= '0;
        end else begin
            state      <= state_nxt;
            aw_done    <= aw_done_nxt;
            w_done     <= w_done_nxt;
            int_seen   <= int_seen_nxt;
            oAWVALID   <= awvalid_nxt;
            oWVALID    <= wvalid_nxt;
            oBREADY    <= bready_nxt;
            oWDATA     <= wdata_nxt;
            oAWADDR    <= awaddr_nxt;
            oAWPROT    <= awprot_nxt;
            oWSTRB     <= wstrb_nxt;
            done       <= done_nxt;
            sent_count <= sent_nxt;
            err_count  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_ga_cmd_streamer.sv
// Self-checking bench for ga_cmd_streamer: scenario table, directed
// corner sequences and randomized traffic against a queue-based model.
module tb_ga_cmd_streamer;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        restart = 1'b0;
    logic [7:0]  oAWADDR;
    logic [2:0]  oAWPROT;
    logic        oAWVALID;
    logic        iAWREADY;
    logic [7:0]  oWDATA;
    logic [0:0]  oWSTRB;
    logic        oWVALID;
    logic        iWREADY;
    logic        oBREADY;
    logic        iBVALID;
    logic [1:0]  iBRESP;
    logic        RenderEndInterrupt = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] sent_count;
    logic [7:0]  err_count;

    ga_cmd_streamer #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8),
        .FIFO_DEPTH (16),
        .CMD_ADDR   (1)
    ) dut (
        .ACLK               (ACLK),
        .ARESETn            (ARESETn),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .restart            (restart),
        .oAWADDR            (oAWADDR),
        .oAWPROT            (oAWPROT),
        .oAWVALID           (oAWVALID),
        .iAWREADY           (iAWREADY),
        .oWDATA             (oWDATA),
        .oWSTRB             (oWSTRB),
        .oWVALID            (oWVALID),
        .iWREADY            (iWREADY),
        .oBREADY            (oBREADY),
        .iBVALID            (iBVALID),
        .iBRESP             (iBRESP),
        .RenderEndInterrupt (RenderEndInterrupt),
        .busy               (busy),
        .done               (done),
        .sent_count         (sent_count),
        .err_count          (err_count)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_errors = 0;

    // slave behaviour knobs (written by main only)
    int aw_lat = 0, w_lat = 0, b_lat = 1, err_txn = 0;
    logic stall = 1'b0, rnd_slave = 1'b0;

    // reference model state (written by monitor only)
    logic [7:0] exp_q[$];
    logic [7:0] exp_cur = '0;
    int m_sent = 0, m_err = 0, b_txn = 0, done_cnt = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model + AXI slave: sampled 1 time unit after each rising edge.
    initial begin : monitor
        logic p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_inr;
        logic [1:0] p_bresp;
        logic [7:0] p_wdata;
        logic aw_hs, w_hs, b_hs;
        int aw_cnt, w_cnt, b_cnt;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_bv = 0; p_br = 0; p_inr = 0;
        p_bresp = '0; p_wdata = '0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        iAWREADY = 0; iWREADY = 0; iBVALID = 0; iBRESP = '0;
        forever begin
            @(posedge ACLK);
            #1;
            if (!ARESETn) begin
                exp_q.delete();
                m_sent = 0; m_err = 0; b_txn = 0;
                p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_bv = 0; p_br = 0; p_inr = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                iAWREADY = 0; iWREADY = 0; iBVALID = 0; iBRESP = '0;
                continue;
            end
            aw_hs = p_awv & p_awr;
            w_hs  = p_wv & p_wr;
            b_hs  = p_bv & p_br;
            if (in_valid && p_inr) exp_q.push_back(in_data);
            if (restart) begin
                exp_q.delete();
                m_sent = 0; m_err = 0; b_txn = 0;
            end
            if (b_hs) begin
                m_sent = (m_sent + 1) % 65536;
                if (p_bresp != 2'b00 && m_err < 255) m_err++;
                b_txn++;
                check("sent_count", 32'(sent_count), m_sent);
                check("err_count", 32'(err_count), m_err);
                check("bready_drop", 32'(oBREADY), 0);
            end
            if (aw_hs) check("awvalid_drop", 32'(oAWVALID), 0);
            else if (p_awv) check("awvalid_hold", 32'(oAWVALID), 1);
            if (w_hs) begin
                check("wvalid_drop", 32'(oWVALID), 0);
                check("wdata_order", 32'(p_wdata), 32'(exp_cur));
            end else if (p_wv) begin
                check("wvalid_hold", 32'(oWVALID), 1);
                check("wdata_stable", 32'(oWDATA), 32'(p_wdata));
            end
            if (oWVALID && !p_wv) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(oWVALID), 0);
                end else begin
                    exp_cur = exp_q.pop_front();
                    check("awaddr", 32'(oAWADDR), 1);
                    check("awprot", 32'(oAWPROT), 2);
                    check("wstrb", 32'(oWSTRB), 1);
                    check("aw_with_w", 32'(oAWVALID), 1);
                end
            end
            if (done) done_cnt++;
            // drive slave for the next edge
            if (stall) begin
                iAWREADY = 0; iWREADY = 0;
            end else if (rnd_slave) begin
                iAWREADY = 1'($urandom % 2);
                iWREADY  = 1'($urandom % 2);
            end else begin
                if (oAWVALID) begin iAWREADY = (aw_cnt >= aw_lat); aw_cnt++; end
                else begin iAWREADY = 0; aw_cnt = 0; end
                if (oWVALID) begin iWREADY = (w_cnt >= w_lat); w_cnt++; end
                else begin iWREADY = 0; w_cnt = 0; end
            end
            if (oBREADY) begin
                if (rnd_slave) begin
                    iBVALID = 1'($urandom % 2);
                    iBRESP  = 2'($urandom % 4);
                end else begin
                    iBVALID = (b_cnt >= b_lat);
                    b_cnt++;
                    iBRESP  = (b_txn + 1 == err_txn) ? 2'b10 : 2'b00;
                end
            end else begin
                iBVALID = 0; iBRESP = '0; b_cnt = 0;
            end
            p_awv = oAWVALID; p_awr = iAWREADY; p_wv = oWVALID; p_wr = iWREADY;
            p_bv = iBVALID; p_br = oBREADY; p_bresp = iBRESP; p_inr = in_ready;
            p_wdata = oWDATA;
        end
    end

    // All main-process tasks start and end on a falling edge.
    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 3000) begin @(negedge ACLK); n++; end
        if (n >= 3000) check("push_timeout", 32'(in_ready), 1);
        @(negedge ACLK);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge ACLK);
        while (busy && n < 5000) begin @(negedge ACLK); n++; end
        check("idle_reached", 32'(busy), 0);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge ACLK);
        restart = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic wait_awvalid();
        int n = 0;
        while (!oAWVALID && n < 200) begin @(negedge ACLK); n++; end
        check("awvalid_seen", 32'(oAWVALID), 1);
    endtask

    typedef struct {
        int nbytes;
        int aw_lat;
        int w_lat;
        int b_lat;
        int err_txn;
        int exp_sent;
        int exp_err;
    } vec_t;

    initial begin : main
        vec_t vecs[5];
        logic [7:0] scene[18];
        int n, d0, bad;
        scene = '{8'h45, 8'h45, 8'h01, 8'h00, 8'h02, 8'h0A, 8'h30, 8'h40, 8'h70,
                  8'h60, 8'h00, 8'h0A, 8'h10, 8'h10, 8'h40, 8'h20, 8'h70, 8'h30};
        vecs[0] = '{18, 0, 0, 1, 0, 18, 0};
        vecs[1] = '{6, 0, 3, 1, 0, 6, 0};
        vecs[2] = '{6, 3, 0, 1, 0, 6, 0};
        vecs[3] = '{8, 0, 0, 1, 3, 8, 1};
        vecs[4] = '{5, 2, 1, 0, 2, 5, 1};

        // reset values
        repeat (2) @(posedge ACLK);
        #1;
        check("rst_awvalid", 32'(oAWVALID), 0);
        check("rst_wvalid", 32'(oWVALID), 0);
        check("rst_bready", 32'(oBREADY), 0);
        check("rst_done", 32'(done), 0);
        check("rst_wdata", 32'(oWDATA), 0);
        check("rst_wstrb", 32'(oWSTRB), 0);
        check("rst_awprot", 32'(oAWPROT), 0);
        check("rst_awaddr", 32'(oAWADDR), 0);
        check("rst_sent", 32'(sent_count), 0);
        check("rst_err", 32'(err_count), 0);
        check("rst_busy", 32'(busy), 0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("rst_in_ready", 32'(in_ready), 1);

        // no bypass: push at edge E1, AWVALID visible only after E2
        in_valid = 1'b1;
        in_data  = 8'h5C;
        @(posedge ACLK);
        #1;
        check("nobypass_e1", 32'(oAWVALID), 0);
        @(negedge ACLK);
        in_valid = 1'b0;
        @(posedge ACLK);
        #1;
        check("launch_e2", 32'(oAWVALID), 1);
        @(negedge ACLK);
        wait_idle();
        check("first_sent", 32'(sent_count), 1);

        // scenario table
        for (int v = 0; v < 5; v++) begin
            aw_lat  = vecs[v].aw_lat;
            w_lat   = vecs[v].w_lat;
            b_lat   = vecs[v].b_lat;
            err_txn = vecs[v].err_txn;
            do_restart();
            for (int i = 0; i < vecs[v].nbytes; i++) begin
                push_byte((v == 0) ? scene[i] : 8'($urandom));
            end
            wait_idle();
            check("vec_sent", 32'(sent_count), vecs[v].exp_sent);
            check("vec_err", 32'(err_count), vecs[v].exp_err);
        end
        aw_lat = 0; w_lat = 0; b_lat = 1; err_txn = 0;

        // FIFO full with a stalled slave: one byte in flight, 16 queued, 17th held
        do_restart();
        stall = 1'b1;
        push_byte(8'h80);
        wait_awvalid();
        for (int i = 0; i < 16; i++) push_byte(8'(8'h81 + i));
        check("full_in_ready", 32'(in_ready), 0);
        in_valid = 1'b1;
        in_data  = 8'h91;
        bad = 0;
        repeat (5) begin
            @(negedge ACLK);
            if (in_ready) bad++;
        end
        check("held_in_ready", bad, 0);
        stall = 1'b0;
        push_byte(8'h91);
        wait_idle();
        check("full_sent", 32'(sent_count), 18);

        // render-end during byte 5 with 3 bytes still queued
        do_restart();
        aw_lat = 4; w_lat = 4; b_lat = 1;
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) push_byte(8'(8'hC0 + i));
        n = 0;
        while (!(sent_count == 16'd4 && oAWVALID) && n < 500) begin @(negedge ACLK); n++; end
        check("byte5_in_send", 32'(oAWVALID), 1);
        RenderEndInterrupt = 1'b1;
        @(negedge ACLK);
        RenderEndInterrupt = 1'b0;
        repeat (60) @(negedge ACLK);
        check("int_sent", 32'(sent_count), 5);
        check("int_done_pulses", done_cnt - d0, 1);
        check("int_in_ready", 32'(in_ready), 0);
        check("int_busy", 32'(busy), 1);
        check("int_unsent", exp_q.size(), 3);
        do_restart();
        check("rs_busy", 32'(busy), 0);
        check("rs_in_ready", 32'(in_ready), 1);
        check("rs_sent", 32'(sent_count), 0);
        aw_lat = 0; w_lat = 0;

        // asynchronous reset in the middle of a transaction
        stall = 1'b1;
        push_byte(8'hA5);
        push_byte(8'h5A);
        wait_awvalid();
        #2;
        ARESETn = 1'b0;
        #1;
        check("arst_awvalid", 32'(oAWVALID), 0);
        check("arst_wvalid", 32'(oWVALID), 0);
        check("arst_wdata", 32'(oWDATA), 0);
        check("arst_busy", 32'(busy), 0);
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        stall = 1'b0;
        @(negedge ACLK);
        for (int i = 0; i < 3; i++) push_byte(8'(8'h31 + i));
        wait_idle();
        check("arst_resume_sent", 32'(sent_count), 3);

        // randomized traffic with a random slave and occasional restarts
        rnd_slave = 1'b1;
        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge ACLK);
            push_byte(8'($urandom));
            if ($urandom_range(0, 24) == 0) do_restart();
        end
        wait_idle();
        check("rnd_sent", 32'(sent_count), m_sent);
        check("rnd_err", 32'(err_count), m_err);
        check("rnd_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
